// File: rtl/ct_ifu_spsram44_arb.sv
// ---------------------------------------------------------------------------
// ct_ifu_spsram44_arb
//
// Purpose:
//   Arbiter and sequencer in front of one single-port 512x44 IFU SRAM macro
//   (A/CEN/GWEN/WEN/D/Q interface). Three sources share the array, highest
//   priority first:
//     1. an internal invalidate walker that writes zero to every address,
//     2. a write (refill/update) requester,
//     3. a read (lookup) requester.
//   A read that keeps losing to writes is promoted above the write once it
//   has lost STARVE_LIMIT consecutive cycles, so reads cannot be starved.
//   Read data returns with a fixed one-cycle latency.
//
// Configuration macro:
//   CT_SPSRAM44_RESET_INIT_EN - when defined, the walker starts by itself on
//   reset release so the array is zeroed before first use. When undefined,
//   the array is cleared only on inv_req.
//
// Ports:
//   CLK, RST          clock (rising edge) / asynchronous active-high reset
//   inv_req           start (or restart) an invalidate walk
//   inv_busy          walker active
//   inv_done          one-cycle pulse after the last walk write
//   wr_vld/addr/data/mask, wr_grant   write request, held until granted
//   rd_vld/addr, rd_grant             read request, held until granted
//   rd_data_vld, rd_data              read return, one cycle after rd_grant
//   sram_a/cen/gwen/wen/d             macro controls (active-low CEN/GWEN/WEN)
//   sram_q                            macro read data
// ---------------------------------------------------------------------------
module ct_ifu_spsram44_arb #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 44,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  inv_req,
  output logic                  inv_busy,
  output logic                  inv_done,
  input  logic                  wr_vld,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_grant,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_grant,
  output logic                  rd_data_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  // Counter wide enough to hold STARVE_LIMIT itself (saturation value).
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } state_e;

`ifdef CT_SPSRAM44_RESET_INIT_EN
  localparam state_e STATE_RST = ST_WALK;
`else
  localparam state_e STATE_RST = ST_IDLE;
`endif

  // Registered state
  state_e                  state_q,       state_d;
  logic [ADDR_WIDTH-1:0]   walk_ptr_q,    walk_ptr_d;
  logic [CNT_W-1:0]        starve_cnt_q,  starve_cnt_d;
  logic                    inv_done_q,    inv_done_d;
  logic                    rd_data_vld_q, rd_data_vld_d;

  // Combinational arbitration results
  logic [ADDR_WIDTH-1:0]   walk_addr_s;
  logic                    read_wins_s;
  logic                    wr_grant_s;
  logic                    rd_grant_s;
  logic [ADDR_WIDTH-1:0]   sram_a_s;
  logic                    sram_cen_s;
  logic                    sram_gwen_s;
  logic [DATA_WIDTH-1:0]   sram_wen_s;
  logic [DATA_WIDTH-1:0]   sram_d_s;

  // Walk address for this cycle; a restart request takes effect immediately,
  // so the restart cycle already writes address 0.
  always_comb begin
    if (inv_req) begin
      walk_addr_s = ADDR_ZERO;
    end else begin
      walk_addr_s = walk_ptr_q;
    end
  end

  // Read beats write only when no write is pending or the read is starved.
  always_comb begin
    if (rd_vld && (!wr_vld || (starve_cnt_q == CNT_MAX))) begin
      read_wins_s = 1'b1;
    end else begin
      read_wins_s = 1'b0;
    end
  end

  // Macro control and grant selection for the current cycle.
  always_comb begin
    wr_grant_s  = 1'b0;
    rd_grant_s  = 1'b0;
    sram_a_s    = ADDR_ZERO;
    sram_cen_s  = 1'b1;
    sram_gwen_s = 1'b1;
    sram_wen_s  = DATA_ONES;
    sram_d_s    = DATA_ZERO;
    case (state_q)
      ST_WALK: begin
        // Full-width zero write; requesters are locked out.
        sram_a_s    = walk_addr_s;
        sram_cen_s  = 1'b0;
        sram_gwen_s = 1'b0;
        sram_wen_s  = DATA_ZERO;
        sram_d_s    = DATA_ZERO;
      end
      ST_IDLE: begin
        if (read_wins_s) begin
          rd_grant_s  = 1'b1;
          sram_a_s    = rd_addr;
          sram_cen_s  = 1'b0;
          sram_gwen_s = 1'b1;
          sram_wen_s  = DATA_ONES;
          sram_d_s    = DATA_ZERO;
        end else if (wr_vld) begin
          // A zero mask is still granted; the macro simply writes no bits.
          wr_grant_s  = 1'b1;
          sram_a_s    = wr_addr;
          sram_cen_s  = 1'b0;
          sram_gwen_s = 1'b0;
          sram_wen_s  = ~wr_mask;
          sram_d_s    = wr_data;
        end else begin
          sram_cen_s  = 1'b1;
        end
      end
      default: begin
        sram_cen_s = 1'b1;
      end
    endcase
  end

  // Walker sequencing: next FSM state, walk pointer and completion pulse.
  always_comb begin
    state_d    = state_q;
    walk_ptr_d = walk_ptr_q;
    inv_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inv_req) begin
          state_d    = ST_WALK;
          walk_ptr_d = ADDR_ZERO;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_WALK: begin
        // Incrementing past the last address wraps the pointer back to 0.
        walk_ptr_d = walk_addr_s + ADDR_ONE;
        if (!inv_req && (walk_ptr_q == ADDR_LAST)) begin
          state_d    = ST_IDLE;
          inv_done_d = 1'b1;
        end else begin
          state_d    = ST_WALK;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        walk_ptr_d = ADDR_ZERO;
      end
    endcase
  end

  // Saturating count of consecutive cycles in which a pending read lost.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == ST_IDLE) begin
      if (rd_grant_s) begin
        starve_cnt_d = CNT_ZERO;
      end else if (rd_vld && (starve_cnt_q != CNT_MAX)) begin
        starve_cnt_d = starve_cnt_q + CNT_ONE;
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Read data is valid in the cycle after the read was granted.
  always_comb begin
    rd_data_vld_d = rd_grant_s;
  end

  // State registers; reset drops any pending read return.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= STATE_RST;
      walk_ptr_q    <= ADDR_ZERO;
      starve_cnt_q  <= CNT_ZERO;
      inv_done_q    <= 1'b0;
      rd_data_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      walk_ptr_q    <= walk_ptr_d;
      starve_cnt_q  <= starve_cnt_d;
      inv_done_q    <= inv_done_d;
      rd_data_vld_q <= rd_data_vld_d;
    end
  end

  assign inv_busy    = (state_q == ST_WALK);
  assign inv_done    = inv_done_q;
  assign rd_data_vld = rd_data_vld_q;
  // Macro Q is only meaningful in the return cycle; squash it otherwise.
  assign rd_data     = rd_data_vld_q ? sram_q : DATA_ZERO;

  assign wr_grant    = wr_grant_s;
  assign rd_grant    = rd_grant_s;
  assign sram_a      = sram_a_s;
  assign sram_cen    = sram_cen_s;
  assign sram_gwen   = sram_gwen_s;
  assign sram_wen    = sram_wen_s;
  assign sram_d      = sram_d_s;

endmodule

// File: tb/tb_ct_ifu_spsram44_arb.sv
// ---------------------------------------------------------------------------
// tb_ct_ifu_spsram44_arb
//
// Directed bench for ct_ifu_spsram44_arb with a behavioural 512x44 macro
// model behind the SRAM port. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ct_ifu_spsram44_arb;

  localparam int AW = 9;
  localparam int DW = 44;

  logic          CLK;
  logic          RST;
  logic          inv_req;
  logic          inv_busy;
  logic          inv_done;
  logic          wr_vld;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] wr_mask;
  logic          wr_grant;
  logic          rd_vld;
  logic [AW-1:0] rd_addr;
  logic          rd_grant;
  logic          rd_data_vld;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int total;
  int bad;

  logic [DW-1:0] mem [0:511];

  ct_ifu_spsram44_arb #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .inv_req     (inv_req),
    .inv_busy    (inv_busy),
    .inv_done    (inv_done),
    .wr_vld      (wr_vld),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .wr_grant    (wr_grant),
    .rd_vld      (rd_vld),
    .rd_addr     (rd_addr),
    .rd_grant    (rd_grant),
    .rd_data_vld (rd_data_vld),
    .rd_data     (rd_data),
    .sram_a      (sram_a),
    .sram_cen    (sram_cen),
    .sram_gwen   (sram_gwen),
    .sram_wen    (sram_wen),
    .sram_d      (sram_d),
    .sram_q      (sram_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural single-port macro: registered Q, bit-masked writes.
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  int busy_cycles;
  int grant_errs;
  int writes;
  int dones;
  bit seq_ok;
  bit done_seen;

  initial begin
    total   = 0;
    bad     = 0;
    RST     = 1'b1;
    inv_req = 1'b0;
    wr_vld  = 1'b0;
    wr_addr = 9'h000;
    wr_data = 44'h0;
    wr_mask = 44'h0;
    rd_vld  = 1'b0;
    rd_addr = 9'h000;
    sram_q  = 44'h0;
    for (int i = 0; i < 512; i++) begin
      mem[i] = 44'h5A5_A5A5_A5A5;
    end

    // ---- reset values ----
    @(negedge CLK);
    chk("rst_inv_busy", 64'(inv_busy), 64'd0);
    chk("rst_inv_done", 64'(inv_done), 64'd0);
    chk("rst_rd_data_vld", 64'(rd_data_vld), 64'd0);
    chk("rst_wr_grant", 64'(wr_grant), 64'd0);
    chk("rst_rd_grant", 64'(rd_grant), 64'd0);
    chk("rst_cen", 64'(sram_cen), 64'd1);
    chk("rst_gwen", 64'(sram_gwen), 64'd1);
    chk("rst_wen", 64'(sram_wen), 64'hFFF_FFFF_FFFF);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_cen", 64'(sram_cen), 64'd1);
    chk("idle_a", 64'(sram_a), 64'd0);
    chk("idle_d", 64'(sram_d), 64'd0);
    chk("idle_rd_data", 64'(rd_data), 64'd0);

    // ---- full walk with both requesters pending ----
    tick();
    inv_req = 1'b1;
    @(negedge CLK);
    chk("walk_req_cycle_busy", 64'(inv_busy), 64'd0);
    tick();
    inv_req = 1'b0;
    wr_vld  = 1'b1;
    wr_addr = 9'h000;
    wr_data = 44'h0;
    wr_mask = 44'h0;
    rd_vld  = 1'b1;
    rd_addr = 9'h005;
    @(negedge CLK);
    chk("walk_busy_first", 64'(inv_busy), 64'd1);
    busy_cycles = 0;
    grant_errs  = 0;
    seq_ok      = 1'b1;
    done_seen   = 1'b0;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      if (c != 0) @(negedge CLK);
      if (inv_done) begin
        done_seen = 1'b1;
        chk("walk_done_busy", 64'(inv_busy), 64'd0);
        chk("walk_done_zero_mask_grant", 64'(wr_grant), 64'd1);
      end else if (inv_busy) begin
        if (sram_a !== 9'(busy_cycles) || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
            sram_wen !== 44'h0 || sram_d !== 44'h0) begin
          seq_ok = 1'b0;
        end
        if (wr_grant || rd_grant) grant_errs++;
        busy_cycles++;
      end
      tick();
    end
    wr_vld = 1'b0;
    rd_vld = 1'b0;
    chk("walk_done_seen", 64'(done_seen), 64'd1);
    chk("walk_busy_cycles", 64'(busy_cycles), 64'd512);
    chk("walk_addr_seq", 64'(seq_ok), 64'd1);
    chk("walk_no_grants", 64'(grant_errs), 64'd0);
    @(negedge CLK);
    chk("walk_done_one_pulse", 64'(inv_done), 64'd0);

    // ---- walk zeroed the array: read address 5 ----
    tick();
    rd_vld  = 1'b1;
    rd_addr = 9'h005;
    @(negedge CLK);
    chk("rd5_grant", 64'(rd_grant), 64'd1);
    tick();
    rd_vld = 1'b0;
    @(negedge CLK);
    chk("rd5_vld", 64'(rd_data_vld), 64'd1);
    chk("rd5_data", 64'(rd_data), 64'd0);

    // ---- full write then read at 1FF ----
    tick();
    wr_vld  = 1'b1;
    wr_addr = 9'h1FF;
    wr_data = 44'h0AB_CDEF_1234;
    wr_mask = 44'hFFF_FFFF_FFFF;
    @(negedge CLK);
    chk("wr1ff_grant", 64'(wr_grant), 64'd1);
    chk("wr1ff_a", 64'(sram_a), 64'h1FF);
    chk("wr1ff_cen", 64'(sram_cen), 64'd0);
    chk("wr1ff_gwen", 64'(sram_gwen), 64'd0);
    chk("wr1ff_wen", 64'(sram_wen), 64'h0);
    chk("wr1ff_d", 64'(sram_d), 64'h0AB_CDEF_1234);
    tick();
    wr_vld  = 1'b0;
    rd_vld  = 1'b1;
    rd_addr = 9'h1FF;
    @(negedge CLK);
    chk("rd1ff_grant", 64'(rd_grant), 64'd1);
    chk("rd1ff_gwen", 64'(sram_gwen), 64'd1);
    chk("rd1ff_wen", 64'(sram_wen), 64'hFFF_FFFF_FFFF);
    chk("rd1ff_vld_same_cycle", 64'(rd_data_vld), 64'd0);
    tick();
    rd_vld = 1'b0;
    @(negedge CLK);
    chk("rd1ff_vld", 64'(rd_data_vld), 64'd1);
    chk("rd1ff_data", 64'(rd_data), 64'h0AB_CDEF_1234);

    // ---- partial mask write ----
    tick();
    wr_vld  = 1'b1;
    wr_addr = 9'h010;
    wr_data = 44'hFFF_FFFF_FFFF;
    wr_mask = 44'hFFF_FFFF_FFFF;
    tick();
    wr_data = 44'h0;
    wr_mask = 44'h000_0000_FFFF;
    @(negedge CLK);
    chk("pmask_grant", 64'(wr_grant), 64'd1);
    chk("pmask_wen", 64'(sram_wen), 64'hFFF_FFFF_0000);
    tick();
    wr_vld  = 1'b0;
    rd_vld  = 1'b1;
    rd_addr = 9'h010;
    tick();
    rd_vld = 1'b0;
    @(negedge CLK);
    chk("pmask_vld", 64'(rd_data_vld), 64'd1);
    chk("pmask_data", 64'(rd_data), 64'hFFF_FFFF_0000);

    // ---- starvation: both held, read wins every 5th cycle ----
    tick();
    wr_vld  = 1'b1;
    wr_addr = 9'h020;
    wr_data = 44'h123_4567_89AB;
    wr_mask = 44'hFFF_FFFF_FFFF;
    rd_vld  = 1'b1;
    rd_addr = 9'h020;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk($sformatf("starve_wr_grant_c%0d", c), 64'(wr_grant), 64'((c % 5) != 4));
      chk($sformatf("starve_rd_grant_c%0d", c), 64'(rd_grant), 64'((c % 5) == 4));
      if (c == 5) chk("starve_rd_return", 64'(rd_data), 64'h123_4567_89AB);
      tick();
    end
    wr_vld = 1'b0;
    rd_vld = 1'b0;

    // ---- walk restarted at address 100 ----
    inv_req = 1'b1;
    tick();
    writes = 0;
    dones  = 0;
    for (int c = 0; c < 800; c++) begin
      inv_req = (c == 100);
      @(negedge CLK);
      if (c == 100) chk("restart_addr", 64'(sram_a), 64'd0);
      if (inv_busy && !sram_cen) writes++;
      if (inv_done) dones++;
      tick();
    end
    inv_req = 1'b0;
    chk("restart_writes", 64'(writes), 64'd612);
    chk("restart_dones", 64'(dones), 64'd1);
    @(negedge CLK);
    chk("restart_idle", 64'(inv_busy), 64'd0);

    // ---- reset right after a read grant ----
    tick();
    rd_vld  = 1'b1;
    rd_addr = 9'h1FF;
    @(negedge CLK);
    chk("rstrd_grant", 64'(rd_grant), 64'd1);
    tick();
    RST    = 1'b1;
    rd_vld = 1'b0;
    @(negedge CLK);
    chk("rstrd_vld", 64'(rd_data_vld), 64'd0);
    chk("rstrd_data", 64'(rd_data), 64'd0);
    chk("rstrd_cen", 64'(sram_cen), 64'd1);
    chk("rstrd_busy", 64'(inv_busy), 64'd0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_vld", 64'(rd_data_vld), 64'd0);
    chk("post_rst_cen", 64'(sram_cen), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_ifu_spsram44_arb.md
# ct_ifu_spsram44_arb

Single-port arbiter and sequencer for one 512x44 IFU SRAM instance (A/CEN/GWEN/WEN/D/Q macro interface).
- Shares the array between three sources, highest priority first: an internal invalidate walker, a write (refill/update) requester, and a read (lookup) requester.
- Drives the macro's active-low controls and returns read data with fixed one-cycle latency.
- Prevents reads from being starved by back-to-back writes.

## Interface
Parameters:
- ADDR_WIDTH, 9, SRAM address width
- DATA_WIDTH, 44, SRAM data/bit-write-mask width
- STARVE_LIMIT, 4, consecutive lost read cycles before read overrides write

Ports:
- CLK  in  1  clock; all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- inv_req  in  1  start invalidate walk (single-cycle pulse or level)
- inv_busy  out  1  walker active
- inv_done  out  1  one-cycle pulse after last walk write
- wr_vld  in  1  write request; held until granted
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_mask  in  DATA_WIDTH  per-bit write enable, 1 = write
- wr_grant  out  1  write accepted this cycle
- rd_vld  in  1  read request; held until granted
- rd_addr  in  ADDR_WIDTH  read address
- rd_grant  out  1  read accepted this cycle
- rd_data_vld  out  1  rd_data valid (one cycle after rd_grant)
- rd_data  out  DATA_WIDTH  read data
- sram_a  out  ADDR_WIDTH  to macro A
- sram_cen  out  1  to macro CEN (active-low)
- sram_gwen  out  1  to macro GWEN (active-low write)
- sram_wen  out  DATA_WIDTH  to macro WEN (active-low per bit)
- sram_d  out  DATA_WIDTH  to macro D
- sram_q  in  DATA_WIDTH  from macro Q

## Operation
- FSM states: IDLE, WALK.
  - IDLE -> WALK on inv_req.
  - WALK -> IDLE after the write to address DEPTH-1 (DEPTH = 2^ADDR_WIDTH).
- WALK behaviour:
  - Each cycle writes zero to walk_ptr: sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0; walk_ptr increments by 1.
  - walk_ptr is ADDR_WIDTH bits and wraps 511 -> 0 on exit.
  - inv_req during WALK restarts walk_ptr at 0; no inv_done is issued for the abandoned walk.
  - wr_grant and rd_grant are 0 throughout WALK.
- Arbitration in IDLE is combinational in the cycle of the request:
  - Write wins over read unless starve_cnt == STARVE_LIMIT; in that case read wins.
  - Write access: sram_a=wr_addr, cen=0, gwen=0, sram_wen=~wr_mask, sram_d=wr_data.
  - wr_mask=0 is still granted; the macro writes no bits.
  - Read access: sram_a=rd_addr, cen=0, gwen=1, sram_wen=all 1.
  - No winner: cen=1, gwen=1, wen=all 1, a=0, d=0.
- starve_cnt (saturating):
  - Increments when rd_vld=1 and rd_grant=0 in IDLE.
  - Clears on rd_grant.
  - Holds during WALK.
- Read return: rd_data_vld is rd_grant registered; rd_data = sram_q passes through combinationally while rd_data_vld=1, and is 0 otherwise.
- Read-after-write to the same address in consecutive grants returns the new data, because the macro serializes accesses.

## Timing
- Reset values:
  - FSM = IDLE (WALK when CT_SPSRAM44_RESET_INIT_EN is defined), walk_ptr=0, starve_cnt=0.
  - inv_busy=0 (1 with the macro), inv_done=0, rd_data_vld=0, grants=0.
  - sram_cen=1, sram_gwen=1, sram_wen=all 1.
- Request/grant: a request presented in cycle N with no higher-priority source is granted in cycle N, with macro controls driven in cycle N. rd_data_vld/rd_data appear in cycle N+1.
- Walk: inv_req at cycle N gives inv_busy=1 from N+1 and writes in cycles N+1..N+512. inv_done pulses at N+513, with inv_busy=0 in that cycle.
- Reset asserted mid-walk or with a read outstanding aborts immediately. The pending rd_data_vld is dropped.
- Simultaneous wr_vld and rd_vld with starve_cnt < STARVE_LIMIT: the write is granted and starve_cnt increments.

## Configuration
- CT_SPSRAM44_RESET_INIT_EN defined: the walker starts automatically on reset release (FSM resets to WALK), so the array is zeroed before first use, and inv_done pulses at the end.
- Undefined: the FSM resets to IDLE and the array is cleared only on inv_req.

## Test plan
- Reset, then inv_req=1 for 1 cycle -> 512 consecutive zero writes at addresses 0..511, inv_busy high for exactly 512 cycles, one inv_done pulse, no grants during the walk.
- Write 44'h0ABC_DEF1234 to address 9'h1FF with mask all 1, then read 9'h1FF -> rd_data_vld one cycle after rd_grant with rd_data=44'h0ABC_DEF1234.
- Partial mask: write all-ones, then write 0 with wr_mask=44'h000_0000_FFFF -> readback 44'hFFF_FFFF_0000.
- wr_vld and rd_vld held high continuously -> writes granted for 4 cycles, read granted in the 5th cycle, then the pattern repeats.
- inv_req again at walk address 100 -> walk restarts at 0 and totals 100+512 write cycles, with a single inv_done.
- RST asserted the cycle after rd_grant -> rd_data_vld stays 0, sram_cen=1, FSM in IDLE (or WALK with the macro defined).
